// File: rtl/bounce_gen_pkg.sv
// Shared types and LFSR helper for the contact-bounce emulator.
package bounce_gen_pkg;

    typedef enum logic {
        BG_IDLE,
        BG_BOUNCE
    } bg_state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Right-shifting Galois step: the bit shifted out folds the taps back in.
    function automatic logic [31:0] lfsr_next(logic [31:0] cur);
        lfsr_next = {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/bounce_gen_ch.sv
// One bounce channel: turns each level change into an odd-length burst of toggles.
module bounce_gen_ch
    import bounce_gen_pkg::*;
#(
    parameter int BOUNCE_W = 3,
    parameter int GAP_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                in_lvl,
    input  logic [BOUNCE_W-1:0] k_rand,
    input  logic [GAP_W-1:0]    g_rand,
    output logic                out_lvl,
    output logic                busy
);

    localparam int TOG_W = BOUNCE_W + 1;
    localparam int CNT_W = GAP_W + 1;
    localparam logic [TOG_W-1:0] TOG_ONE = TOG_W'(1);
    localparam logic [CNT_W-1:0] GAP_ONE = CNT_W'(1);

    bg_state_t        state_q, state_d;
    logic             settled_q, settled_d;
    logic             target_q, target_d;
    logic             out_q, out_d;
    logic [TOG_W-1:0] toggles_left_q, toggles_left_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;

    logic [TOG_W-1:0] tog_load;
    logic [CNT_W-1:0] gap_load;

    // 2k+1 is just k with a forced trailing one, which keeps the burst odd.
    assign tog_load = {k_rand, 1'b1};
    assign gap_load = {1'b0, g_rand} + GAP_ONE;

    always_comb begin
        state_d        = state_q;
        settled_d      = settled_q;
        target_d       = target_q;
        out_d          = out_q;
        toggles_left_d = toggles_left_q;
        gap_cnt_d      = gap_cnt_q;
        if (ena) begin
            case (state_q)
                BG_IDLE: begin
                    if (in_lvl != settled_q) begin
                        state_d        = BG_BOUNCE;
                        target_d       = in_lvl;
                        toggles_left_d = tog_load;
                        gap_cnt_d      = gap_load;
                    end
                end
                BG_BOUNCE: begin
                    if (gap_cnt_q > GAP_ONE) begin
                        gap_cnt_d = gap_cnt_q - GAP_ONE;
                    end else begin
                        out_d          = ~out_q;
                        toggles_left_d = toggles_left_q - TOG_ONE;
                        gap_cnt_d      = gap_load;
                        if (toggles_left_q == TOG_ONE) begin
                            state_d   = BG_IDLE;
                            settled_d = target_q;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= BG_IDLE;
            settled_q      <= 1'b0;
            target_q       <= 1'b0;
            out_q          <= 1'b0;
            toggles_left_q <= '0;
            gap_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            settled_q      <= settled_d;
            target_q       <= target_d;
            out_q          <= out_d;
            toggles_left_q <= toggles_left_d;
            gap_cnt_q      <= gap_cnt_d;
        end
    end

    assign out_lvl = out_q;
    assign busy    = (state_q == BG_BOUNCE);

endmodule

// File: rtl/bounce_gen.sv
// Multi-channel contact-bounce emulator driven by one seeded, repeatable LFSR.
module bounce_gen
    import bounce_gen_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int          BOUNCE_W = 3,
    parameter int          GAP_W    = 4,
    parameter logic [31:0] SEED     = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] busy
);

    // An all-zero LFSR would lock up, so a zero seed is quietly promoted to one.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam int          STRIDE   = BOUNCE_W + GAP_W;

    logic [31:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (ena) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [BOUNCE_W-1:0] k_rand;
        logic [GAP_W-1:0]    g_rand;

        // Each channel taps a fixed, wrapping window of the shared LFSR.
        for (genvar j = 0; j < BOUNCE_W; j++) begin : g_k
            assign k_rand[j] = lfsr_q[(i*STRIDE + j) % 32];
        end
        for (genvar j = 0; j < GAP_W; j++) begin : g_g
            assign g_rand[j] = lfsr_q[(i*STRIDE + BOUNCE_W + j) % 32];
        end

        bounce_gen_ch #(
            .BOUNCE_W(BOUNCE_W),
            .GAP_W   (GAP_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .ena    (ena),
            .in_lvl (in[i]),
            .k_rand (k_rand),
            .g_rand (g_rand),
            .out_lvl(out[i]),
            .busy   (busy[i])
        );
    end

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen: hand-checked timing plus a behavioural reference model.
module tb_bounce_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] in_v;
    logic [0:0] in_min;

    logic [7:0] out_m, busy_m, out_z, busy_z, out_b, busy_b;
    logic [0:0] out_min, busy_min;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bounce_gen #(.SEED(32'h0000_0001)) u_main (
        .clk(clk), .rst(rst), .ena(ena), .in(in_v), .out(out_m), .busy(busy_m));

    bounce_gen #(.SEED(32'h0000_0000)) u_zero (
        .clk(clk), .rst(rst), .ena(ena), .in(in_v), .out(out_z), .busy(busy_z));

    bounce_gen #(.SEED(32'hDEAD_BEEF)) u_beef (
        .clk(clk), .rst(rst), .ena(ena), .in(in_v), .out(out_b), .busy(busy_b));

    bounce_gen #(.WIDTH(1), .BOUNCE_W(1), .GAP_W(1), .SEED(32'h0000_0001)) u_min (
        .clk(clk), .rst(rst), .ena(ena), .in(in_min), .out(out_min), .busy(busy_min));

    // Reference model: index 0 models seed 1 (also seed 0), index 1 models seed DEADBEEF.
    logic [31:0] m_lfsr [2];
    logic [7:0]  m_out  [2];
    logic [7:0]  m_busy [2];
    logic [7:0]  m_set  [2];
    logic [7:0]  m_tgt  [2];
    int          m_tog  [2][8];
    int          m_gap  [2][8];
    logic [7:0]  trace  [160];

    function automatic logic [31:0] ref_step(logic [31:0] x);
        if (x[0]) return (x >> 1) ^ 32'h8020_0003;
        return x >> 1;
    endfunction

    function automatic int ref_bits(logic [31:0] x, int ch, int lo, int n);
        int v = 0;
        for (int j = 0; j < n; j++) begin
            if (x[(ch*7 + lo + j) % 32]) v += (1 << j);
        end
        return v;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_lfsr[m] = (m == 0) ? 32'h1 : 32'hDEAD_BEEF;
                m_out[m]  = 8'h00;
                m_busy[m] = 8'h00;
                m_set[m]  = 8'h00;
                m_tgt[m]  = 8'h00;
            end else if (ena) begin
                for (int i = 0; i < 8; i++) begin
                    int k;
                    int g;
                    k = ref_bits(m_lfsr[m], i, 0, 3);
                    g = ref_bits(m_lfsr[m], i, 3, 4);
                    if (!m_busy[m][i]) begin
                        if (in_v[i] != m_set[m][i]) begin
                            m_busy[m][i] = 1'b1;
                            m_tgt[m][i]  = in_v[i];
                            m_tog[m][i]  = 2*k + 1;
                            m_gap[m][i]  = g + 1;
                        end
                    end else if (m_gap[m][i] > 1) begin
                        m_gap[m][i] = m_gap[m][i] - 1;
                    end else begin
                        m_out[m][i] = ~m_out[m][i];
                        m_tog[m][i] = m_tog[m][i] - 1;
                        m_gap[m][i] = g + 1;
                        if (m_tog[m][i] == 0) begin
                            m_busy[m][i] = 1'b0;
                            m_set[m][i]  = m_tgt[m][i];
                        end
                    end
                end
                m_lfsr[m] = ref_step(m_lfsr[m]);
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        in_v = 8'hFF;
        repeat (3) begin
            tick();
            n_checks++;
            if ({out_m, busy_m, out_b, busy_b} !== 32'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_hold: actual out/busy %h %h required 00 00", out_m, busy_m);
            end
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy_m !== 8'hFF || busy_b !== 8'hFF) begin
            n_fail++;
            $display("[TB] FAIL reset_release_busy: actual %h/%h required ff", busy_m, busy_b);
        end
        n_checks++;
        if (out_m !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_release_out: actual %h required 00", out_m);
        end
        in_v = 8'h00;
        rst  = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_single_burst;
        int  cyc;
        int  tog;
        logic prev;
        logic done;
        repeat (3) tick();
        in_v[0] = 1'b1;
        tick();
        n_checks++;
        if (busy_m[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL burst_start: actual busy %b required 1", busy_m[0]);
        end
        cyc  = 0;
        tog  = 0;
        prev = out_m[0];
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            tick();
            cyc++;
            n_checks++;
            if ({out_m, busy_m, out_z, busy_z} !== {m_out[0], m_busy[0], m_out[0], m_busy[0]}) begin
                n_fail++;
                $display("[TB] FAIL burst_model: actual %h %h %h %h required %h %h", out_m, busy_m, out_z, busy_z, m_out[0], m_busy[0]);
            end
            if (out_m[0] !== prev) begin
                tog++;
                n_checks++;
                if (cyc < 1 || cyc > 16) begin
                    n_fail++;
                    $display("[TB] FAIL burst_gap: actual %0d required 1..16", cyc);
                end
                cyc  = 0;
                prev = out_m[0];
            end
            if (!busy_m[0]) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("[TB] FAIL burst_timeout: actual busy %b required 0", busy_m[0]);
        end
        n_checks++;
        if (tog % 2 != 1 || tog > 15) begin
            n_fail++;
            $display("[TB] FAIL burst_toggle_count: actual %0d required odd <= 15", tog);
        end
        n_checks++;
        if (out_m[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL burst_final: actual %b required 1", out_m[0]);
        end
    endtask

    task automatic test_min_latency;
        logic found = 1'b0;
        logic exp_lvl;
        for (int n = 0; n < 200 && !found; n++) begin
            if (m_lfsr[0][1:0] == 2'b00 && busy_min[0] == 1'b0) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL minlat_search: actual no zero slot required one within 200");
        end else begin
            in_min[0] = ~in_min[0];
            exp_lvl   = in_min[0];
            tick();
            n_checks++;
            if (busy_min[0] !== 1'b1 || out_min[0] !== ~exp_lvl) begin
                n_fail++;
                $display("[TB] FAIL minlat_sample: actual busy %b out %b required 1 %b", busy_min[0], out_min[0], ~exp_lvl);
            end
            tick();
            n_checks++;
            if (busy_min[0] !== 1'b0 || out_min[0] !== exp_lvl) begin
                n_fail++;
                $display("[TB] FAIL minlat_toggle: actual busy %b out %b required 0 %b", busy_min[0], out_min[0], exp_lvl);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic done;
        in_v[1] = 1'b1;
        tick();
        n_checks++;
        if (busy_m[1] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_start: actual busy %b required 1", busy_m[1]);
        end
        tick();
        in_v[1] = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            done = 1'b0;
            for (int n = 0; n < 300; n++) begin
                n_checks++;
                if ({out_m, busy_m} !== {m_out[0], m_busy[0]}) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_model: actual %h %h required %h %h", out_m, busy_m, m_out[0], m_busy[0]);
                end
                if (!busy_m[1]) begin
                    done = 1'b1;
                    break;
                end
                tick();
            end
            n_checks++;
            if (!done || out_m[1] !== (pass == 0 ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("[TB] FAIL b2b_settle%0d: actual done %b out %b required 1 %b", pass, done, out_m[1], (pass == 0));
            end
            if (pass == 0) begin
                tick();
                n_checks++;
                if (busy_m[1] !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_restart: actual busy %b required 1", busy_m[1]);
                end
            end
        end
    endtask

    task automatic test_ena_freeze;
        logic [7:0]  frz_out;
        logic [7:0]  frz_busy;
        logic [31:0] frz_lfsr;
        logic        done = 1'b0;
        in_v[2] = 1'b1;
        tick();
        n_checks++;
        if (busy_m[2] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL freeze_start: actual busy %b required 1", busy_m[2]);
        end
        ena      = 1'b0;
        frz_out  = m_out[0];
        frz_busy = m_busy[0];
        frz_lfsr = m_lfsr[0];
        repeat (50) begin
            tick();
            n_checks++;
            if ({out_m, busy_m, u_main.lfsr_q} !== {frz_out, frz_busy, frz_lfsr}) begin
                n_fail++;
                $display("[TB] FAIL freeze_hold: actual %h %h %h required %h %h %h", out_m, busy_m, u_main.lfsr_q, frz_out, frz_busy, frz_lfsr);
            end
        end
        ena = 1'b1;
        for (int n = 0; n < 300 && !done; n++) begin
            tick();
            n_checks++;
            if ({out_m, busy_m} !== {m_out[0], m_busy[0]}) begin
                n_fail++;
                $display("[TB] FAIL freeze_resume: actual %h %h required %h %h", out_m, busy_m, m_out[0], m_busy[0]);
            end
            if (!busy_m[2]) done = 1'b1;
        end
        n_checks++;
        if (!done || out_m[2] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL freeze_final: actual done %b out %b required 1 1", done, out_m[2]);
        end
    endtask

    task automatic test_repeatability;
        for (int run = 0; run < 2; run++) begin
            in_v = 8'h00;
            rst  = 1'b1;
            repeat (2) tick();
            rst = 1'b0;
            for (int c = 0; c < 160; c++) begin
                if (c == 2)  in_v = 8'hA5;
                if (c == 60) in_v = 8'h3C;
                if (c == 75) in_v = 8'h5A;
                tick();
                n_checks++;
                if ({out_b, busy_b, out_z, busy_z} !== {m_out[1], m_busy[1], m_out[0], m_busy[0]}) begin
                    n_fail++;
                    $display("[TB] FAIL repeat_model run%0d c%0d: actual %h %h %h %h required %h %h %h %h", run, c, out_b, busy_b, out_z, busy_z, m_out[1], m_busy[1], m_out[0], m_busy[0]);
                end
                if (run == 0) begin
                    trace[c] = m_out[1];
                end else begin
                    n_checks++;
                    if (out_b !== trace[c]) begin
                        n_fail++;
                        $display("[TB] FAIL repeat_trace c%0d: actual %h required %h", c, out_b, trace[c]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        in_v   = 8'h00;
        in_min = 1'b0;
        test_reset();
        test_single_burst();
        test_min_latency();
        test_back_to_back();
        test_ena_freeze();
        test_repeatability();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
